// File: rtl/div5_scheduler.sv
// div5_scheduler
//   Round-robin front end for a single serial divide-by-five checker shared
//   by NUM_REQ requesters. A granted word is latched, the checker is cleared
//   for one cycle, the word is shifted in MSB-first and the checker's
//   divisible flag is returned with the requester id over valid/ready.
// Ports
//   clk, rst              clock; synchronous active-high reset
//   req_valid/req_data    per-requester request; word i at [i*WIDTH +: WIDTH]
//   req_ready             one-hot accept pulse (IDLE only)
//   chk_clr/chk_bit       checker control: clear (active high), serial bit
//   chk_div               checker output: bits so far divisible by 5
//   resp_valid/resp_ready response handshake
//   resp_id/word/div      served requester, checked word, divisible result
//   busy                  high whenever the FSM is not IDLE
module div5_scheduler #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     chk_clr,
  output logic                     chk_bit,
  input  logic                     chk_div,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_word,
  output logic                     resp_div,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, SAMPLE, RESP} state_t;

  state_t           state, state_nx;
  logic [ID_W-1:0]  ptr;      // last granted requester
  logic [CNT_W-1:0] cnt;      // bit index being shifted
  logic [WIDTH-1:0] word_q;
  logic [ID_W-1:0]  id_q;
  logic             div_q;

  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;
  logic [WIDTH-1:0] gnt_word;
  logic             accept;

  // Round-robin search starting just after the last grant, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    gnt_word = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld  = 1'b1;
        gnt_id   = ID_W'(idx);
        gnt_word = req_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by rst so nothing is offered while the reset is being applied.
  assign accept = (state == IDLE) && gnt_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CLEAR;
      CLEAR:   state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = SAMPLE;
      SAMPLE:  state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= ID_W'(NUM_REQ - 1);
      cnt    <= '0;
      word_q <= '0;
      id_q   <= '0;
      div_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          word_q <= gnt_word;
          id_q   <= gnt_id;
          ptr    <= gnt_id;
        end
        CLEAR:  cnt <= CNT_W'(WIDTH - 1);
        SHIFT:  if (cnt != '0) cnt <= cnt - 1'b1;
        // Checker has absorbed the last bit by now.
        SAMPLE: div_q <= chk_div;
        default: ;
      endcase
    end
  end

  // Clear is combinational so the checker is held in reset for the whole rst.
  assign chk_clr    = rst | (state == CLEAR);
  assign chk_bit    = !rst && (state == SHIFT) && word_q[cnt];
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign resp_id    = id_q;
  assign resp_word  = word_q;
  assign resp_div   = div_q;

endmodule

// File: tb/tb_div5_scheduler.sv
module tb_div5_scheduler;
  localparam int NR = 4;
  localparam int W  = 8;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     vmask;
  logic [NR*W-1:0]   dreg;
  logic [NR-1:0]     req_ready;
  logic              chk_clr, chk_bit, chk_div;
  logic              resp_valid, resp_ready;
  logic [1:0]        resp_id;
  logic [W-1:0]      resp_word;
  logic              resp_div;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;
  int last_g   = NR - 1;
  bit obs_div;

  div5_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(vmask), .req_data(dreg),
    .req_ready(req_ready), .chk_clr(chk_clr), .chk_bit(chk_bit),
    .chk_div(chk_div), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_word(resp_word), .resp_div(resp_div),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial mod-5 checker: remainder of the bits shifted in so far.
  int unsigned rem = 0;
  always @(posedge clk) begin
    if (chk_clr) rem <= 0;
    else         rem <= (rem * 2 + chk_bit) % 5;
  end
  assign chk_div = (rem == 0);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Priority order is every requester after the last grant, then the rest.
  function automatic int rr_pick(input logic [NR-1:0] m, input int last);
    int order[$];
    for (int i = last + 1; i < NR; i++) order.push_back(i);
    for (int i = 0; i <= last; i++) order.push_back(i);
    foreach (order[k]) if (m[order[k]]) return order[k];
    return -1;
  endfunction

  // One complete job: accept, clear, shift, sample, response (+stall).
  task automatic serve(input int stall, input bit drop, input logic [NR-1:0] add_m,
                       input logic [NR-1:0] late_drop, input bit back_to_back);
    int w;
    int g;
    logic [W-1:0]  word;
    logic [NR-1:0] oh;
    bit div;
    resp_ready = (stall == 0);
    #1;
    w = 0;
    while (req_ready == '0 && w < 40) begin cyc(); w++; end
    if (back_to_back) check("b2b_gap", 64'(w), 0);
    g  = rr_pick(vmask, last_g);
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    check("grant", req_ready, oh);
    check("busy_idle", busy, 0);
    if (g < 0) return;
    word   = dreg[g*W +: W];
    last_g = g;
    div    = (word % 5 == 0);
    cyc();
    check("clr_pulse", chk_clr, 1);
    check("busy_clr", busy, 1);
    check("rdy_busy", req_ready, 0);
    if (drop) vmask[g] = 1'b0;
    dreg[g*W +: W] = W'($urandom);
    vmask = vmask | add_m;
    for (int i = 0; i < W; i++) begin
      cyc();
      check("chk_bit", chk_bit, word[W-1-i]);
      check("clr_shift", chk_clr, 0);
    end
    cyc();
    check("vld_sample", resp_valid, 0);
    cyc();
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, g);
    check("resp_word", resp_word, word);
    check("resp_div", resp_div, div);
    obs_div = resp_div;
    for (int j = 0; j < stall; j++) begin
      cyc();
      check("stall_valid", resp_valid, 1);
      check("stall_id", resp_id, g);
      check("stall_word", resp_word, word);
      check("stall_div", resp_div, div);
      check("stall_busy", busy, 1);
      check("stall_rdy", req_ready, 0);
    end
    resp_ready = 1'b1;
    vmask = vmask & ~late_drop;
    cyc();
    check("post_valid", resp_valid, 0);
    check("post_busy", busy, 0);
  endtask

  logic [W-1:0] tbl_v [5] = '{8'd0, 8'd5, 8'd26, 8'd254, 8'd255};
  bit           tbl_d [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [NR-1:0] rnd;
    rst = 1'b1; vmask = '1; dreg = '0; resp_ready = 1'b0;

    // Reset state, with all requesters already valid.
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_clr", chk_clr, 1);
      check("rst_ready", req_ready, 0);
      check("rst_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_bit", chk_bit, 0);
      check("rst_id", resp_id, 0);
      check("rst_word", resp_word, 0);
      check("rst_div", resp_div, 0);
    end
    for (int i = 0; i < NR; i++) dreg[i*W +: W] = W'($urandom);
    rst = 1'b0; last_g = NR - 1;

    // All requesters held valid: grants 0,1,2,3,0 back to back.
    for (int i = 0; i < 5; i++) serve(0, 0, '0, '0, 1);
    vmask = '0;

    // Requester 1 with 25.
    dreg[1*W +: W] = 8'd25; vmask = 4'b0010;
    serve(0, 1, '0, '0, 1);

    // Directed table, then full sweep from requester 0.
    for (int i = 0; i < 5; i++) begin
      dreg[W-1:0] = tbl_v[i]; vmask = 4'b0001;
      serve(0, 1, '0, '0, 1);
      check("tbl_div", obs_div, tbl_d[i]);
    end
    for (int v = 0; v < 256; v++) begin
      dreg[W-1:0] = W'(v); vmask = 4'b0001;
      serve(0, 1, '0, '0, 1);
    end

    // Long response stall with requester 3 waiting.
    vmask = 4'b0100;
    serve(19, 1, 4'b1000, '0, 1);
    serve(0, 1, '0, '0, 1);

    // Requester 2 withdraws just before the arbitration cycle.
    vmask = 4'b0010;
    serve(0, 1, 4'b0101, 4'b0100, 1);
    serve(0, 1, '0, '0, 1);

    // Reset during the 4th shift cycle.
    vmask = 4'b0010;
    #1;
    check("t5_grant", req_ready, 4'b0010);
    last_g = 1;
    cyc();
    vmask = '0;
    for (int i = 0; i < 4; i++) cyc();
    rst = 1'b1; vmask = 4'b1001;
    #1;
    check("t5_clr", chk_clr, 1);
    check("t5_bit", chk_bit, 0);
    check("t5_rdy", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_valid", resp_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_clr_hold", chk_clr, 1);
    end
    rst = 1'b0; last_g = NR - 1;
    serve(0, 1, '0, '0, 1);
    serve(0, 1, '0, '0, 1);

    // Random traffic: masks, data and stalls.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR; i++)
        if (!vmask[i]) dreg[i*W +: W] = W'($urandom);
      rnd = NR'($urandom_range(1, (1 << NR) - 1));
      vmask = vmask | rnd;
      serve($urandom_range(0, 3), 1, '0, '0, 1);
    end
    vmask = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
